spi_cfg_peripheral: RTL and testbench
=====================================

// Module: spi_cfg_peripheral
// PURPOSE
//   Write-only SPI slave (mode 0) that owns the five PWM configuration registers. It drives
//   pwm_peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle.
//   Sits in the top-level beside pwm_peripheral. SPI pins arrive on ui_in (sclk, copi, ncs).
//   Pins are synchronised into clk; a register updates only on a complete, valid 16-bit frame.
// PARAMETERS
//   SYNC_STAGES  2    flip-flop depth of each input synchroniser (>=2)
//   NUM_REGS     5    number of implemented registers, at addresses 0..NUM_REGS-1
//   ADDR_W       7    address field width in the frame
//   DATA_W       8    data field width in the frame
// PORTS
//   clk              in   1  system clock
//   rst_n            in   1  asynchronous reset, active low
//   sclk             in   1  SPI clock (async to clk), idles low
//   copi             in   1  SPI data in, sampled on sclk rising edge
//   ncs              in   1  SPI chip select, active low
//   cipo             out  1  SPI data out (see CONFIGURATION)
//   en_reg_out_7_0   out  8  reg 0x00
//   en_reg_out_15_8  out  8  reg 0x01
//   en_reg_pwm_7_0   out  8  reg 0x02
//   en_reg_pwm_15_8  out  8  reg 0x03
//   pwm_duty_cycle   out  8  reg 0x04
//   cfg_update       out  1  one-clk pulse when any register is written
// BEHAVIOUR
//   - Reset: all five registers = 8'h00, cfg_update = 0, cipo = 0, state = IDLE, bit count = 0.
//   - Sync: sclk, copi, ncs each pass through SYNC_STAGES FFs. Edges are detected on the last
//     stage vs. one extra delayed copy. Each sclk phase must be >= 3 clk periods.
//   - Frame, MSB first, 16 bits: [15] R/W (1 = write), [14:8] address, [7:0] data.
//   - FSM states: IDLE, SHIFT, COMMIT.
//     IDLE   -> SHIFT on synced ncs falling edge; clear shift register and bit count.
//     SHIFT  on synced sclk rising edge with ncs low: shift in copi, count++ (saturates at 17).
//     SHIFT  -> COMMIT on synced ncs rising edge.
//     COMMIT -> IDLE after 1 cycle. Writes only if count == 16, R/W == 1 and address < NUM_REGS.
//       On a write: the addressed register takes the data and cfg_update = 1 for that cycle.
//   - Latency: register output changes SYNC_STAGES+2 clk cycles after pin ncs rises.
//   - Discard the frame, with no register change and no pulse, when:
//     fewer than 16 bits; more than 16 bits; R/W = 0; address >= NUM_REGS.
//   - Same-cycle sclk rise and ncs rise (synced): the sclk edge is ignored; the frame is judged
//     on the bits already counted.
//   - ncs low at reset release: stay in IDLE until an ncs rise then fall is seen. No partial capture.
//   - Reset mid-frame clears the FSM, the shift register and all five registers.
//   - Registers hold their value between frames; back-to-back frames are independent.
// CONFIGURATION
//   SPI_CFG_READBACK_EN defined:
//     In a frame with R/W = 0, after the 8th rising sclk edge, cipo presents the addressed
//     register MSB first, changing after each synced sclk falling edge.
//     cipo = 0 for an invalid address and whenever ncs is high. A read frame never writes.
//   SPI_CFG_READBACK_EN undefined: cipo tied 0; read frames discarded as above.
// STRUCTURE
//   - Package spi_cfg_pkg holds:
//     constants FRAME_W = 16 and ADDR_EN_OUT_LO = 7'h00, ADDR_EN_OUT_HI = 7'h01,
//     ADDR_EN_PWM_LO = 7'h02, ADDR_EN_PWM_HI = 7'h03, ADDR_DUTY = 7'h04;
//     the FSM state encoding.
//   - Sub-module cdc_sync_bit (parameter SYNC_STAGES): async-reset FF chain, reset value 0 for
//     sclk/copi and 1 for ncs. Instantiated three times.
// TESTING
//   1. Reset: all outputs 0. Write 0x80FF (addr 0, data FF) -> en_reg_out_7_0 = FF,
//      cfg_update pulses once.
//   2. Write all five registers: 0x80F0, 0x810F, 0x82AA, 0x8355, 0x8480 -> each register holds
//      its value; the other registers are unchanged.
//   3. Invalid frames: address 0x05 (0x8512); R/W = 0 (0x0033); 15 bits; 17 bits
//      -> no register change, no cfg_update.
//   4. Assert rst_n low after 9 bits of 0x8299, then send a full 0x8244
//      -> en_reg_pwm_7_0 = 00 during reset, then 44.
//   5. Timing: sclk at clk/8, then at the minimum (3 clk per phase); measure the ncs-rise to
//      output latency = SYNC_STAGES+2 clk cycles.
//   6. (SPI_CFG_READBACK_EN) write 0x84C3, then read frame 0x0400 -> cipo shifts 1100_0011.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared frame constants, register addresses and FSM encoding for spi_cfg_peripheral.
package spi_cfg_pkg;

  localparam int FRAME_W = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchroniser: SYNC_STAGES flip-flops with a selectable reset value.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {SYNC_STAGES{RST_VAL}};
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cfg_peripheral.sv
// Write-only SPI mode-0 slave holding the five PWM configuration registers.
// Optional register readback on cipo is enabled by defining SPI_CFG_READBACK_EN.
module spi_cfg_peripheral
  import spi_cfg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              cfg_update
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_d, ncs_d;
  logic sclk_rise, ncs_rise, ncs_fall;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ncs_d  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  state_t                 state;
  logic [FRAME_W-1:0]     sr;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] live;
  logic                   armed;
  logic [DATA_W-1:0]      regs [NUM_REGS];
  logic [ADDR_W-1:0]      f_addr;
  logic [DATA_W-1:0]      f_data;
  logic                   frame_ok;

  assign f_addr   = sr[FRAME_W-2 -: ADDR_W];
  assign f_data   = sr[DATA_W-1:0];
  assign frame_ok = (cnt == CNT_W'(FRAME_W)) && sr[FRAME_W-1] && (32'(f_addr) < NUM_REGS);

  // The ncs synchroniser resets high, so a low pin at reset release would look like a
  // falling edge; `live` marks when ncs_s reflects the pin, and a high must be seen first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sr         <= '0;
      cnt        <= '0;
      live       <= '0;
      armed      <= 1'b0;
      cfg_update <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      live       <= {live[SYNC_STAGES-2:0], 1'b1};
      armed      <= armed | (live[SYNC_STAGES-1] & ncs_s);
      cfg_update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall && armed) begin
            state <= ST_SHIFT;
            sr    <= '0;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            state <= ST_COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            sr <= {sr[FRAME_W-2:0], copi_s};
            if (cnt != CNT_W'(FRAME_W + 1)) cnt <= cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (frame_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (f_addr == ADDR_W'(i)) regs[i] <= f_data;
            cfg_update <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[IDX_W'(ADDR_EN_OUT_LO)];
  assign en_reg_out_15_8 = regs[IDX_W'(ADDR_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = regs[IDX_W'(ADDR_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = regs[IDX_W'(ADDR_EN_PWM_HI)];
  assign pwm_duty_cycle  = regs[IDX_W'(ADDR_DUTY)];

`ifdef SPI_CFG_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-2:0] rd_sr;

  assign sclk_fall = ~sclk_s & sclk_d;

  // After 8 bits the R/W flag and address sit in the low bits of the shift register.
  always_comb begin
    rd_val = '0;
    if (!sr[ADDR_W])
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (sr[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo  <= 1'b0;
      rd_sr <= '0;
    end else if (state != ST_SHIFT || ncs_s) begin
      cipo  <= 1'b0;
      rd_sr <= '0;
    end else if (sclk_fall) begin
      if (cnt == CNT_W'(1 + ADDR_W)) begin
        cipo  <= rd_val[DATA_W-1];
        rd_sr <= rd_val[DATA_W-2:0];
      end else if (cnt > CNT_W'(1 + ADDR_W) && cnt < CNT_W'(FRAME_W)) begin
        cipo  <= rd_sr[DATA_W-2];
        rd_sr <= {rd_sr[DATA_W-3:0], 1'b0};
      end
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_peripheral.sv
// Self-checking bench for spi_cfg_peripheral: vector table, corner sequences, random frames.
module tb_spi_cfg_peripheral;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       cfg_update;
  logic [7:0] dout [5];

  spi_cfg_peripheral #(.SYNC_STAGES(SYNC), .NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .cfg_update(cfg_update));

  always #5 clk = ~clk;

  assign dout[0] = r0;
  assign dout[1] = r1;
  assign dout[2] = r2;
  assign dout[3] = r3;
  assign dout[4] = r4;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [7:0] exp_regs [5];

  always @(negedge clk) if (rst_n && cfg_update) pulses++;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          exp_wr;
    int          exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int half,
                           output logic [15:0] rx);
    ncs = 1'b0;
    rx  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(half);
      rx   = {rx[14:0], cipo};
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int half);
    wait_clk(half);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clk(8);
  endtask

  task automatic send_frame(input logic [31:0] v, input int n, input int half);
    logic [15:0] rx;
    send_bits(v, n, half, rx);
    end_frame(half);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_reg%0d", tag, i), {24'h0, dout[i]}, {24'h0, exp_regs[i]});
  endtask

  initial begin
    vec_t        vecs [10];
    logic [15:0] rx;
    int          p0, lat;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic        rw;
    logic [15:0] word;
    logic [31:0] fbits;
    int          nb;

    vecs[0] = '{32'h80FF, 16, 1'b1, 0, 8'hFF};
    vecs[1] = '{32'h80F0, 16, 1'b1, 0, 8'hF0};
    vecs[2] = '{32'h810F, 16, 1'b1, 1, 8'h0F};
    vecs[3] = '{32'h82AA, 16, 1'b1, 2, 8'hAA};
    vecs[4] = '{32'h8355, 16, 1'b1, 3, 8'h55};
    vecs[5] = '{32'h8480, 16, 1'b1, 4, 8'h80};
    vecs[6] = '{32'h8512, 16, 1'b0, 0, 8'h00};
    vecs[7] = '{32'h0033, 16, 1'b0, 0, 8'h00};
    vecs[8] = '{32'h4155, 15, 1'b0, 0, 8'h00};
    vecs[9] = '{32'h10567, 17, 1'b0, 0, 8'h00};
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

    wait_clk(5);
    check_regs("reset");
    check("reset_cfg_update", {31'h0, cfg_update}, 32'h0);
    check("reset_cipo", {31'h0, cipo}, 32'h0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      send_frame(vecs[i].bits, vecs[i].nbits, 4);
      if (vecs[i].exp_wr) exp_regs[vecs[i].exp_addr] = vecs[i].exp_data;
      check_regs($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_wr ? 1 : 0);
    end

    // Reset in the middle of a frame, then a clean write.
    send_bits(32'h105, 9, 4, rx);
    rst_n = 1'b0;
    wait_clk(3);
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    check_regs("midreset");
    check("midreset_cfg_update", {31'h0, cfg_update}, 32'h0);
    ncs  = 1'b1;
    sclk = 1'b0;
    rst_n = 1'b1;
    wait_clk(10);
    p0 = pulses;
    send_frame(32'h8244, 16, 4);
    exp_regs[2] = 8'h44;
    check_regs("after_reset");
    check("after_reset_pulses", pulses - p0, 1);

    // ncs already low at reset release: this frame must not be captured.
    ncs = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    wait_clk(6);
    p0 = pulses;
    send_frame(32'h8011, 16, 4);
    check_regs("ncs_low_rst");
    check("ncs_low_rst_pulses", pulses - p0, 0);
    p0 = pulses;
    send_frame(32'h8011, 16, 4);
    exp_regs[0] = 8'h11;
    check_regs("ncs_low_rst_next");
    check("ncs_low_rst_next_pulses", pulses - p0, 1);

    // sclk and ncs rising together: the extra edge is ignored, frame stays 16 bits.
    p0 = pulses;
    send_bits(32'h8166, 16, 4, rx);
    wait_clk(4);
    sclk = 1'b1;
    ncs  = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(6);
    exp_regs[1] = 8'h66;
    check_regs("same_edge");
    check("same_edge_pulses", pulses - p0, 1);

    // ncs-rise to output latency at clk/8 and at the minimum sclk phase.
    for (int k = 0; k < 2; k++) begin
      data = (k == 0) ? 8'h77 : 8'h88;
      send_bits({16'h0, 8'h83, data}, 16, (k == 0) ? 4 : 3, rx);
      wait_clk(3);
      ncs = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        #1;
        if (lat < 0 && dout[3] == data) lat = c;
      end
      exp_regs[3] = data;
      check($sformatf("latency_%0d", k), lat, SYNC + 2);
      wait_clk(4);
    end

    // Random frames against a rule-level model.
    for (int n = 0; n < 40; n++) begin
      addr = 7'($urandom_range(0, 7));
      data = 8'($urandom);
      rw   = ($urandom_range(0, 3) != 0);
      word = {rw, addr, data};
      case ($urandom_range(0, 4))
        0:       begin nb = 15; fbits = {17'h0, word[15:1]}; end
        1:       begin nb = 17; fbits = {15'h0, word, 1'($urandom)}; end
        default: begin nb = 16; fbits = {16'h0, word}; end
      endcase
      p0 = pulses;
      send_frame(fbits, nb, int'($urandom_range(3, 5)));
      if (nb == 16 && rw && addr < 5) exp_regs[addr] = data;
      check_regs($sformatf("rand%0d", n));
      check($sformatf("rand%0d_pulses", n), pulses - p0,
            (nb == 16 && rw && addr < 5) ? 1 : 0);
    end

    // Read frame: readback shifts the register out, otherwise cipo stays low.
    send_frame(32'h84C3, 16, 4);
    exp_regs[4] = 8'hC3;
    p0 = pulses;
    send_bits(32'h0400, 16, 4, rx);
    end_frame(4);
`ifdef SPI_CFG_READBACK_EN
    check("readback_data", {16'h0, rx}, 32'h00C3);
`else
    check("readback_data", {16'h0, rx}, 32'h0000);
`endif
    check_regs("read_frame");
    check("read_frame_pulses", pulses - p0, 0);
    check("idle_cipo", {31'h0, cipo}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
